// File: rtl/load_store_unit_pkg.sv
// -----------------------------------------------------------------------------
// rv32_lsu_pkg
// Shared definitions for the load/store unit: the fun3 access-size encodings,
// the LSU state type and the byte-strobe width.
// -----------------------------------------------------------------------------
package rv32_lsu_pkg;

  // fun3 access size / sign encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte-strobe width for a 32-bit data bus
  localparam int MASK_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/load_store_unit_load_extend.sv
// -----------------------------------------------------------------------------
// load_extend
// Combinational load formatter: picks the addressed byte/half/word from the
// memory read word and sign- or zero-extends it according to fun3.
// Ports:
//   rdata_i  32-bit word returned by data memory
//   off_i    byte offset within the word (addr[1:0])
//   fun3_i   access size/sign
//   data_o   extended 32-bit load result (0 for unsupported fun3)
// -----------------------------------------------------------------------------
module load_extend
  import rv32_lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  fun3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned, which would infer a latch.
    data_o   = '0;
    byte_sel = rdata_i[{off_i, 3'b000} +: 8];
    // Halfword selection uses off[1] only; an odd offset is not a lane.
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (fun3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_W:    data_o = rdata_i;
      F3_BU:   data_o = {24'b0, byte_sel};
      F3_HU:   data_o = {16'b0, half_sel};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Data-memory interface stage behind the control decoder. Accepts a load or
// store, runs a req/ack transaction with data memory, formats store lanes and
// strobes, extends load data and returns a one-cycle DM_valid pulse.
//
// Optional feature: define LSU_MISALIGN_TRAP_EN to flag misaligned halfword
// and word accesses; those skip the memory transaction and complete at once
// with misalign_o = 1 and load_data_o = 0.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   load_i, store_i          operation present (load wins if both high)
//   fun3_i, addr_i           access size/sign and byte address
//   store_data_i             rs2 store value
//   dm_req_o, dm_we_o        memory request and write enable
//   dm_addr_o                word-aligned address
//   dm_wdata_o, dm_mask_o    lane-replicated store data and byte strobes
//   dm_rdata_i, dm_ack_i     memory read word and completion
//   DM_valid                 one-cycle completion pulse
//   load_data_o, misalign_o  results, valid with DM_valid
//   stall_o                  hold PC/pipeline while the access is in flight
// -----------------------------------------------------------------------------
module load_store_unit
  import rv32_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FUNCTION3  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  store_i,
  input  logic [FUNCTION3-1:0]  fun3_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] store_data_i,
  output logic                  dm_req_o,
  output logic                  dm_we_o,
  output logic [ADDR_WIDTH-1:0] dm_addr_o,
  output logic [DATA_WIDTH-1:0] dm_wdata_o,
  output logic [MASK_W-1:0]     dm_mask_o,
  input  logic [DATA_WIDTH-1:0] dm_rdata_i,
  input  logic                  dm_ack_i,
  output logic                  DM_valid,
  output logic [DATA_WIDTH-1:0] load_data_o,
  output logic                  stall_o,
  output logic                  misalign_o
);

  lsu_state_t            state_q, state_d;
  logic                  accept;
  logic                  mis_now;
  logic                  is_load_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [FUNCTION3-1:0]  fun3_q;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_fmt;
  logic [MASK_W-1:0]     mask_q, mask_fmt;
  logic [DATA_WIDTH-1:0] load_data_q, ext_data;

  assign accept = (state_q == IDLE) && (load_i || store_i);

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_q;
  // Halfwords trap on an odd address, words on any non-zero offset.
  assign mis_now = (((fun3_i == F3_H) || (load_i && (fun3_i == F3_HU))) && addr_i[0])
                 || ((fun3_i == F3_W) && (addr_i[1:0] != 2'b00));
  assign misalign_o = misalign_q;
`else
  assign mis_now    = 1'b0;
  assign misalign_o = 1'b0;
`endif

  // Store lane replication and strobes, computed from the inputs so they can
  // be captured together with the address on accept.
  always_comb begin
    mask_fmt  = '0;
    wdata_fmt = store_data_i;
    if (load_i) begin
      mask_fmt = 4'b1111;
    end else begin
      case (fun3_i)
        F3_B: begin
          mask_fmt  = 4'b0001 << addr_i[1:0];
          wdata_fmt = {4{store_data_i[7:0]}};
        end
        F3_H: begin
          mask_fmt  = addr_i[1] ? 4'b1100 : 4'b0011;
          wdata_fmt = {2{store_data_i[15:0]}};
        end
        F3_W:    mask_fmt = 4'b1111;
        default: mask_fmt = 4'b0000;
      endcase
    end
  end

  // Next state and handshake outputs
  always_comb begin
    state_d  = state_q;
    dm_req_o = 1'b0;
    DM_valid = 1'b0;
    stall_o  = 1'b0;
    case (state_q)
      IDLE: begin
        stall_o = load_i || store_i;
        if (accept) state_d = mis_now ? DONE : REQ;
      end
      REQ: begin
        dm_req_o = 1'b1;
        stall_o  = 1'b1;
        if (dm_ack_i) state_d = DONE;
      end
      DONE: begin
        // Inputs are ignored here: the decoder still drives the op this cycle.
        DM_valid = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  load_extend u_load_extend (
    .rdata_i (dm_rdata_i),
    .off_i   (addr_q[1:0]),
    .fun3_i  (fun3_q),
    .data_o  (ext_data)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= IDLE;
      is_load_q   <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      fun3_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      load_data_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        is_load_q <= load_i;
        we_q      <= !load_i;
        addr_q    <= addr_i;
        fun3_q    <= fun3_i;
        wdata_q   <= wdata_fmt;
        mask_q    <= mask_fmt;
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_q <= mis_now;
`endif
        if (mis_now) load_data_q <= '0;
      end else if ((state_q == REQ) && dm_ack_i) begin
        load_data_q <= is_load_q ? ext_data : '0;
      end
    end
  end

  assign dm_we_o     = we_q;
  assign dm_addr_o   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign dm_wdata_o  = wdata_q;
  assign dm_mask_o   = mask_q;
  assign load_data_o = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Directed bench for load_store_unit. A transaction-level model derives the
// expected per-cycle handshake and the expected field values from the access
// rules; one compare process checks the DUT against it on every falling edge.
// Literal expectations after selected operations pin the model itself.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_i = 1'b0, store_i = 1'b0;
  logic [2:0]  fun3_i = '0;
  logic [31:0] addr_i = '0, store_data_i = '0, dm_rdata_i = '0;
  logic        dm_ack_i = 1'b0;
  logic        dm_req_o, dm_we_o, DM_valid, stall_o, misalign_o;
  logic [31:0] dm_addr_o, dm_wdata_o, load_data_o;
  logic [3:0]  dm_mask_o;

  load_store_unit dut (
    .clk(clk), .rst(rst), .load_i(load_i), .store_i(store_i), .fun3_i(fun3_i),
    .addr_i(addr_i), .store_data_i(store_data_i), .dm_req_o(dm_req_o),
    .dm_we_o(dm_we_o), .dm_addr_o(dm_addr_o), .dm_wdata_o(dm_wdata_o),
    .dm_mask_o(dm_mask_o), .dm_rdata_i(dm_rdata_i), .dm_ack_i(dm_ack_i),
    .DM_valid(DM_valid), .load_data_o(load_data_o), .stall_o(stall_o),
    .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  function automatic logic [3:0] model_mask(input bit ld, input logic [2:0] f3, input logic [31:0] a);
    int unsigned off;
    off = {30'b0, a[1:0]};
    if (ld) return 4'hF;
    case (f3)
      3'b000:  return 4'(1 << off);
      3'b001:  return 4'(3 << (off & 2));
      3'b010:  return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  return d[7:0] * 32'h0101_0101;
      3'b001:  return d[15:0] * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    int unsigned off, b, h;
    off = {30'b0, a[1:0]};
    b = (rd >> (8 * off)) & 32'hFF;
    h = (rd >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128) ? b - 256 : b;
      3'b001:  return (h >= 32768) ? h - 65536 : h;
      3'b010:  return rd;
      3'b100:  return b;
      3'b101:  return h;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit model_misaligned(input bit ld, input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
    return (((f3 == 3'b001) || (ld && f3 == 3'b101)) && a[0]) || ((f3 == 3'b010) && (a[1:0] != 2'b00));
`else
    return 1'b0;
`endif
  endfunction

  // Expected outputs for the current cycle, written by the driver.
  bit          chk_en = 1'b0;
  bit          exp_req, exp_valid, exp_stall, exp_we, exp_ld, exp_mis;
  logic [31:0] exp_addr, exp_wdata, exp_load;
  logic [3:0]  exp_mask;

  always @(negedge clk) begin
    if (chk_en) begin
      check("req", 32'(dm_req_o), 32'(exp_req));
      check("stall", 32'(stall_o), 32'(exp_stall));
      check("valid", 32'(DM_valid), 32'(exp_valid));
      if (exp_req) begin
        check("addr", dm_addr_o, exp_addr);
        check("we", 32'(dm_we_o), 32'(exp_we));
        check("mask", 32'(dm_mask_o), 32'(exp_mask));
        if (exp_we) check("wdata", dm_wdata_o, exp_wdata);
      end
      if (exp_valid) begin
        check("misalign", 32'(misalign_o), 32'(exp_mis));
        if (exp_ld) check("load_data", load_data_o, exp_load);
      end
    end
  end

  // One operation: accept cycle, (waits+1) request cycles, DONE cycle.
  // Returns during the DONE cycle so a following op is accepted back-to-back.
  task automatic do_op(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic [31:0] rd, input int waits,
                       input bit hold);
    bit mis;
    mis = model_misaligned(ld, f3, a);
    @(posedge clk); #1;
    load_i = ld; store_i = !ld; fun3_i = f3; addr_i = a; store_data_i = sd;
    dm_rdata_i = rd; dm_ack_i = 1'b0;
    exp_req = 0; exp_valid = 0; exp_stall = 1; chk_en = 1;
    if (!mis) begin
      for (int i = 0; i <= waits; i++) begin
        @(posedge clk); #1;
        if (!hold) begin load_i = 0; store_i = 0; end
        dm_ack_i  = (i == waits);
        exp_req   = 1; exp_stall = 1; exp_valid = 0;
        exp_addr  = a & 32'hFFFF_FFFC;
        exp_we    = !ld;
        exp_mask  = model_mask(ld, f3, a);
        exp_wdata = model_wdata(f3, sd);
      end
    end
    @(posedge clk); #1;
    if (!hold) begin load_i = 0; store_i = 0; end
    dm_ack_i   = 1'b0;
    dm_rdata_i = ~rd;  // result must come from the registered capture
    exp_req = 0; exp_valid = 1; exp_stall = 0;
    exp_ld  = ld; exp_mis = mis;
    exp_load = mis ? 32'h0 : model_load(f3, a, rd);
  endtask

  task automatic idle(input int n, input bit ack);
    repeat (n) begin
      @(posedge clk); #1;
      load_i = 0; store_i = 0; dm_ack_i = ack;
      exp_req = 0; exp_valid = 0; exp_stall = 0; chk_en = 1;
    end
    dm_ack_i = 0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(dm_req_o), 0);
    check("rst_we", 32'(dm_we_o), 0);
    check("rst_valid", 32'(DM_valid), 0);
    check("rst_mis", 32'(misalign_o), 0);
    check("rst_addr", dm_addr_o, 0);
    check("rst_wdata", dm_wdata_o, 0);
    check("rst_mask", 32'(dm_mask_o), 0);
    check("rst_ld", load_data_o, 0);
    rst = 1'b0;
    idle(1, 0);

    // SW, ack on first request cycle
    do_op(0, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0, 0, 0);
    check("sw_addr_lit", dm_addr_o, 32'h10);
    check("sw_mask_lit", 32'(dm_mask_o), 32'hF);
    check("sw_wdata_lit", dm_wdata_o, 32'hDEAD_BEEF);
    check("sw_stall_lit", 32'(stall_o), 0);
    idle(1, 0);

    // LB / LBU at 0x23
    do_op(1, 3'b000, 32'h23, 32'h0, 32'h80FF_1234, 0, 0);
    check("lb_lit", load_data_o, 32'hFFFF_FF80);
    do_op(1, 3'b100, 32'h23, 32'h0, 32'h80FF_1234, 0, 0);
    check("lbu_lit", load_data_o, 32'h0000_0080);

    // LH / LHU at 0x2 with a three-cycle ack delay
    do_op(1, 3'b001, 32'h2, 32'h0, 32'h8001_7FFF, 3, 0);
    check("lh_lit", load_data_o, 32'hFFFF_8001);
    do_op(1, 3'b101, 32'h2, 32'h0, 32'h8001_7FFF, 1, 0);
    check("lhu_lit", load_data_o, 32'h0000_8001);

    // SB then SH back-to-back; SH holds store_i through DONE
    do_op(0, 3'b000, 32'h41, 32'h0000_00AB, 32'h0, 0, 0);
    check("sb_mask_lit", 32'(dm_mask_o), 32'b0010);
    check("sb_wdata_lit", dm_wdata_o, 32'hABAB_ABAB);
    do_op(0, 3'b001, 32'h42, 32'h0000_1234, 32'h0, 1, 1);
    check("sh_mask_lit", 32'(dm_mask_o), 32'b1100);
    check("sh_wdata_lit", dm_wdata_o, 32'h1234_1234);
    idle(2, 0);

    // Unsupported fun3: store with no strobes, load returning 0
    do_op(0, 3'b011, 32'h8, 32'h55, 32'h0, 0, 0);
    check("st_f3x_mask_lit", 32'(dm_mask_o), 0);
    do_op(1, 3'b011, 32'h8, 32'h0, 32'hFFFF_FFFF, 0, 0);
    check("ld_f3x_lit", load_data_o, 0);

    // LW at 0x6: misaligned trap or word-aligned read depending on build
    do_op(1, 3'b010, 32'h6, 32'h0, 32'hCAFE_F00D, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lw_mis_lit", 32'(misalign_o), 1);
    check("lw_mis_data_lit", load_data_o, 0);
`else
    check("lw_data_lit", load_data_o, 32'hCAFE_F00D);
    check("lw_addr_lit", dm_addr_o, 32'h4);
`endif
    idle(1, 0);

    // Reset while in REQ, then a late ack
    @(posedge clk); #1;
    load_i = 1; fun3_i = 3'b010; addr_i = 32'h8; dm_rdata_i = 32'h1111_2222;
    exp_req = 0; exp_valid = 0; exp_stall = 1; chk_en = 1;
    @(posedge clk); #1;
    load_i = 0;
    exp_req = 1; exp_stall = 1; exp_we = 0; exp_addr = 32'h8; exp_mask = 4'hF;
    @(posedge clk); #1;
    chk_en = 0;
    check("pre_rst_req", 32'(dm_req_o), 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check("rst_mid_req", 32'(dm_req_o), 0);
    check("rst_mid_valid", 32'(DM_valid), 0);
    check("rst_mid_stall", 32'(stall_o), 0);
    dm_ack_i = 1;
    @(posedge clk); #1;
    dm_ack_i = 0;
    check("late_ack_valid", 32'(DM_valid), 0);
    check("late_ack_req", 32'(dm_req_o), 0);
    idle(2, 0);

    // Spurious ack in IDLE
    idle(2, 1);
    idle(2, 0);

    // A transaction still completes normally afterwards
    do_op(1, 3'b000, 32'h1, 32'h0, 32'h0000_7F00, 0, 0);
    check("lb_pos_lit", load_data_o, 32'h0000_007F);
    idle(2, 0);

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
